rgst: RTL and testbench

- Generic w-bit storage register with asynchronous reset, synchronous clear and synchronous load enable.
- Basic state element of the datapath. Used for input pipeline registers (e.g. 10-bit operand capture) and for accumulator registers (e.g. 16-bit running sum fed back through an adder).
- Instantiated with `ld` tied high and `clr` tied low when used as a plain pipeline register.

---
 rtl/rgst_if.sv | 19 +
 rtl/rgst.sv | 53 +++++
 tb/tb_rgst.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rgst_if.sv
// rtl/rgst_if.sv - control/data bundle for the rgst storage register.
// Optional macro RGST_PARITY_EN adds the registered parity bit q_par.
interface rgst_if #(
    parameter int w = 8
);
    logic         ld;
    logic         clr;
    logic [w-1:0] d;
    logic [w-1:0] q;
`ifdef RGST_PARITY_EN
    logic         q_par;

    modport master (output ld, output clr, output d, input q, input q_par);
    modport slave  (input ld, input clr, input d, output q, output q_par);
`else
    modport master (output ld, output clr, output d, input q);
    modport slave  (input ld, input clr, input d, output q);
`endif
endinterface

// File: rtl/rgst.sv
// rtl/rgst.sv - w-bit register: async reset to RST_VAL, sync clear > load > hold.
// Optional macro RGST_PARITY_EN adds registered even parity output q_par.
module rgst #(
    parameter int           w       = 8,
    parameter logic [w-1:0] RST_VAL = '0
) (
    input  logic  clk,
    input  logic  rst_b,
    rgst_if.slave bus
);
    logic [w-1:0] q_d;
    logic [w-1:0] q_q;

    // Clear wins over load and yields all zeros, not RST_VAL.
    always_comb begin
        q_d = q_q;
        if (bus.clr) begin
            q_d = '0;
        end else if (bus.ld) begin
            q_d = bus.d;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q = q_q;

`ifdef RGST_PARITY_EN
    logic par_d;
    logic par_q;

    // Parity of the value being loaded keeps q_par aligned with q; clear gives 0.
    always_comb begin
        par_d = ^q_d;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            par_q <= ^RST_VAL;
        end else begin
            par_q <= par_d;
        end
    end

    assign bus.q_par = par_q;
`endif
endmodule

// File: tb/tb_rgst.sv
// tb/tb_rgst.sv - directed self-checking bench for rgst (16-bit, 10-bit, accumulator, parity).
module tb_rgst;
    logic clk;
    logic rst_b;
    int   total;
    int   bad;

    rgst_if #(.w(16)) a_if ();
    rgst_if #(.w(10)) b_if ();

    rgst #(.w(16)) u_a (.clk(clk), .rst_b(rst_b), .bus(a_if.slave));
    rgst #(.w(10)) u_b (.clk(clk), .rst_b(rst_b), .bus(b_if.slave));

`ifdef RGST_PARITY_EN
    rgst_if #(.w(16)) p_if ();
    rgst #(.w(16), .RST_VAL(16'h0001)) u_p (.clk(clk), .rst_b(rst_b), .bus(p_if.slave));
`endif

    logic        acc_mode;
    logic [15:0] a_d_tb;

    // In accumulator mode the 16-bit register feeds back through an adder with the 10-bit stage.
    always_comb begin
        a_if.d = acc_mode ? (a_if.q + {6'd0, b_if.q}) : a_d_tb;
    end

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unknown ld/clr at an active edge is a protocol violation.
    always @(posedge clk) begin
        if (!rst_b && $isunknown({a_if.ld, a_if.clr, b_if.ld, b_if.clr})) begin
            check("ctl_known", 32'd1, 32'd0);
        end
    end

    initial begin
        logic [9:0] v;
        total    = 0;
        bad      = 0;
        rst_b    = 1'b1;
        acc_mode = 1'b0;
        a_d_tb   = 16'h0;
        a_if.ld  = 1'b0;
        a_if.clr = 1'b0;
        b_if.ld  = 1'b0;
        b_if.clr = 1'b0;
        b_if.d   = 10'h0;
`ifdef RGST_PARITY_EN
        p_if.ld  = 1'b0;
        p_if.clr = 1'b0;
        p_if.d   = 16'h0;
`endif
        #10;
        check("rst_a", 32'(a_if.q), 32'h0);
        check("rst_b", 32'(b_if.q), 32'h0);
`ifdef RGST_PARITY_EN
        check("par_rst_q", 32'(p_if.q), 32'h0001);
        check("par_rst", 32'(p_if.q_par), 32'd1);
`endif
        tick();
        check("rst_held_known", 32'($isunknown(a_if.q)), 32'd0);
        rst_b = 1'b0;

        // Async reset mid-cycle on a preloaded 16-bit register
        a_if.ld = 1'b1;
        a_d_tb  = 16'h1234;
        tick();
        check("preload", 32'(a_if.q), 32'h1234);
        #24;
        rst_b = 1'b1;
        #1;
        check("async_rst", 32'(a_if.q), 32'h0);
        a_d_tb = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold", 32'(a_if.q), 32'h0);
        end
        rst_b   = 1'b0;
        a_if.ld = 1'b0;

        // Load pipeline: each edge captures d, nothing before the edge
        b_if.ld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = 10'(1 + 3 * i);
            b_if.d = v;
            #1;
            check("pipe_pre", 32'(b_if.q), (i == 0) ? 32'h0 : 32'(v - 10'd3));
            tick();
            check("pipe", 32'(b_if.q), 32'(v));
        end

        // Hold
        b_if.d = 10'h2A5;
        tick();
        check("hold_load", 32'(b_if.q), 32'h2A5);
        b_if.ld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_if.d = 10'($urandom_range(0, 1023));
            tick();
            check("hold", 32'(b_if.q), 32'h2A5);
        end

        // Clear priority over load
        b_if.ld = 1'b1;
        b_if.d  = 10'h3FF;
        tick();
        check("clr_pre", 32'(b_if.q), 32'h3FF);
        b_if.clr = 1'b1;
        b_if.d   = 10'h155;
        tick();
        check("clr_prio", 32'(b_if.q), 32'h000);
        b_if.clr = 1'b0;
        tick();
        check("clr_after", 32'(b_if.q), 32'h155);

        // Accumulator: clear both stages, then feed x = 1, 4, 7, ...
        a_if.clr = 1'b1;
        b_if.clr = 1'b1;
        tick();
        check("acc_clr", 32'(a_if.q), 32'h0);
        a_if.clr = 1'b0;
        b_if.clr = 1'b0;
        a_if.ld  = 1'b1;
        acc_mode = 1'b1;
        for (int i = 0; i < 199; i++) begin
            b_if.d = 10'(1 + 3 * i);
            tick();
        end
        b_if.clr = 1'b1;
        tick();
        tick();
        check("acc_sum199", 32'(a_if.q), 32'd59302);
        b_if.clr = 1'b0;
        for (int i = 199; i < 210; i++) begin
            b_if.d = 10'(1 + 3 * i);
            tick();
        end
        b_if.clr = 1'b1;
        tick();
        tick();
        check("acc_wrap210", 32'(a_if.q), 32'd509);
        check("acc_known", 32'($isunknown(a_if.q)), 32'd0);
        b_if.clr = 1'b0;
        a_if.ld  = 1'b0;
        acc_mode = 1'b0;

`ifdef RGST_PARITY_EN
        p_if.ld = 1'b1;
        p_if.d  = 16'h0007;
        tick();
        check("par_7", 32'(p_if.q_par), 32'd1);
        p_if.d = 16'h0003;
        tick();
        check("par_3", 32'(p_if.q_par), 32'd0);
        p_if.clr = 1'b1;
        tick();
        check("par_clr", 32'(p_if.q_par), 32'd0);
        p_if.clr = 1'b0;
        p_if.d   = 16'h8001;
        tick();
        check("par_8001", 32'(p_if.q_par), 32'd0);
        #24;
        rst_b = 1'b1;
        #1;
        check("par_async_rst", 32'(p_if.q_par), 32'd1);
        tick();
        rst_b = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
